// File: rtl/uart_packet_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_packet_parser_pkg
// Description : Shared constants for the UART packet parser: number of
//               destinations, packet prefix byte, FSM state encodings and a
//               destination-to-one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_packet_parser_pkg;

  // Number of destination FIFOs driven by valid_bus.
  localparam int N_SRC = 4;

  // Packet start-of-frame byte.
  localparam logic [7:0] SYNC_BYTE = 8'hDD;

  // Parser states. SKIP_LEN/SKIP discard a packet with a bad destination
  // while still honouring its length field.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SRC      = 4'd1;
  localparam logic [3:0] ST_DST      = 4'd2;
  localparam logic [3:0] ST_LEN      = 4'd3;
  localparam logic [3:0] ST_DATA     = 4'd4;
  localparam logic [3:0] ST_CRC      = 4'd5;
  localparam logic [3:0] ST_DRAIN    = 4'd6;
  localparam logic [3:0] ST_SKIP_LEN = 4'd7;
  localparam logic [3:0] ST_SKIP     = 4'd8;

  // One-hot strobe for a (known good) destination index.
  function automatic logic [N_SRC-1:0] dst_onehot(input logic [7:0] dst);
    logic [N_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      oh[i] = (dst == 8'(i));
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_packet_parser_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_packet_parser_buf
// Description : Simple dual-port payload buffer, DEPTH x 8, synchronous write
//               and registered read (1-cycle read latency).
// Ports       : clk     - system clock
//               wr_en   - write strobe
//               wr_addr - write address
//               wr_data - write byte
//               rd_addr - read address (sampled every cycle)
//               rd_data - byte at rd_addr from the previous cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_packet_parser_buf #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // No reset: contents are don't-care after reset and the read register is
  // never observed outside DRAIN.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_packet_parser
// Description : Frames DD|src|dst|len|payload|crc packets from the UART byte
//               stream and strobes each payload byte to one destination.
//               CRC is the 8-bit sum of the payload bytes.
// Build macro : PARSER_CRC_CHECK_EN - store-and-forward: payload is buffered
//               and only released (DRAIN) after a good CRC. Undefined:
//               cut-through delivery, no buffer, overrun tied low.
// Ports       : clk, n_rst (async active-low)
//               rx_data/rx_valid  - received byte stream
//               master_data       - payload byte to destinations
//               valid_bus         - one-hot destination strobe
//               src_addr          - src byte of the latest packet
//               pkt_done, crc_err, dst_err, timeout_err, overrun - pulses
//               busy              - parser not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_packet_parser
  import uart_packet_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = 48000,
  parameter int BUF_DEPTH   = 256
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       master_data,
  output logic [N_SRC-1:0] valid_bus,
  output logic [7:0]       src_addr,
  output logic             pkt_done,
  output logic             crc_err,
  output logic             dst_err,
  output logic             timeout_err,
  output logic             overrun,
  output logic             busy
);

  if (BUF_DEPTH < 256) begin : g_depth_check
    $error("BUF_DEPTH must be at least 256");
  end

  logic [3:0]       state_q, state_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       dst_q, dst_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       crc_q, crc_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       md_q, md_d;
  logic [N_SRC-1:0] vb_q, vb_d;
  logic             pkt_done_q, pkt_done_d;
  logic             crc_err_q, crc_err_d;
  logic             dst_err_q, dst_err_d;
  logic             tmo_err_q, tmo_err_d;
  logic             tmo_run;

`ifdef PARSER_CRC_CHECK_EN
  localparam int ADDR_W = $clog2(BUF_DEPTH);

  logic              overrun_q, overrun_d;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [7:0]        buf_rd_data;

  // Read address runs one ahead of the drain counter so that the byte for
  // counter value k is already in the read register when DRAIN reaches k.
  assign buf_wr_addr = ADDR_W'(cnt_q);
  assign buf_rd_addr = (state_q == ST_DRAIN) ? ADDR_W'(cnt_q + 8'd1) : '0;

  uart_packet_parser_buf #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_parser_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_wr_addr),
    .wr_data (rx_data),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );
`endif

  // Inter-byte timer is frozen in IDLE and while draining the buffer.
  assign tmo_run = (state_q != ST_IDLE) && (state_q != ST_DRAIN);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    md_d       = md_q;
    vb_d       = '0;
    pkt_done_d = 1'b0;
    crc_err_d  = 1'b0;
    dst_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    tmo_d      = (tmo_run && !rx_valid) ? tmo_q + 16'd1 : 16'd0;
`ifdef PARSER_CRC_CHECK_EN
    overrun_d  = 1'b0;
    buf_wr_en  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_SRC;
      end
      ST_SRC: begin
        if (rx_valid) begin
          src_d   = rx_data;
          state_d = ST_DST;
        end
      end
      ST_DST: begin
        if (rx_valid) begin
          dst_d = rx_data;
          if (rx_data >= 8'(N_SRC)) begin
            dst_err_d = 1'b1;
            state_d   = ST_SKIP_LEN;
          end else begin
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          len_d   = rx_data;
          crc_d   = 8'd0;
          cnt_d   = 8'd0;
          state_d = (rx_data == 8'd0) ? ST_CRC : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          crc_d = crc_q + rx_data;
          cnt_d = cnt_q + 8'd1;
`ifdef PARSER_CRC_CHECK_EN
          buf_wr_en = 1'b1;
`else
          md_d = rx_data;
          vb_d = dst_onehot(dst_q);
`endif
          if ((cnt_q + 8'd1) == len_q) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        if (rx_valid) begin
          state_d = ST_IDLE;
          if (rx_data == crc_q) begin
`ifdef PARSER_CRC_CHECK_EN
            cnt_d = 8'd0;
            if (len_q == 8'd0) pkt_done_d = 1'b1;
            else               state_d    = ST_DRAIN;
`else
            pkt_done_d = 1'b1;
`endif
          end else begin
            crc_err_d = 1'b1;
          end
        end
      end
`ifdef PARSER_CRC_CHECK_EN
      ST_DRAIN: begin
        overrun_d = rx_valid;
        // One extra cycle after the last byte carries pkt_done.
        if (cnt_q == len_q) begin
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          md_d  = buf_rd_data;
          vb_d  = dst_onehot(dst_q);
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      ST_SKIP_LEN: begin
        if (rx_valid) begin
          len_d   = rx_data;
          cnt_d   = 8'd0;
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        // Swallows len payload bytes plus the CRC byte.
        if (rx_valid) begin
          if (cnt_q == len_q) state_d = ST_IDLE;
          else                cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_run && !rx_valid && (tmo_q == 16'(TIMEOUT_CYC - 1))) begin
      tmo_err_d = 1'b1;
      tmo_d     = 16'd0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      src_q      <= 8'd0;
      dst_q      <= 8'd0;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      crc_q      <= 8'd0;
      tmo_q      <= 16'd0;
      md_q       <= 8'd0;
      vb_q       <= '0;
      pkt_done_q <= 1'b0;
      crc_err_q  <= 1'b0;
      dst_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      tmo_q      <= tmo_d;
      md_q       <= md_d;
      vb_q       <= vb_d;
      pkt_done_q <= pkt_done_d;
      crc_err_q  <= crc_err_d;
      dst_err_q  <= dst_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

`ifdef PARSER_CRC_CHECK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign master_data = md_q;
  assign valid_bus   = vb_q;
  assign src_addr    = src_q;
  assign pkt_done    = pkt_done_q;
  assign crc_err     = crc_err_q;
  assign dst_err     = dst_err_q;
  assign timeout_err = tmo_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_packet_parser
// Description : Directed self-checking bench for uart_packet_parser.
//               Expected values follow PARSER_CRC_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_packet_parser;
  import uart_packet_parser_pkg::*;

  localparam int TMO = 48000;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_valid = 1'b0;
  logic [7:0]       master_data;
  logic [N_SRC-1:0] valid_bus;
  logic [7:0]       src_addr;
  logic             pkt_done, crc_err, dst_err, timeout_err, overrun, busy;

  always #5 clk = ~clk;

  uart_packet_parser #(
    .TIMEOUT_CYC (TMO),
    .BUF_DEPTH   (256)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .master_data (master_data),
    .valid_bus   (valid_bus),
    .src_addr    (src_addr),
    .pkt_done    (pkt_done),
    .crc_err     (crc_err),
    .dst_err     (dst_err),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Output monitor, sampled on the falling edge.
  logic [7:0]       mon_data[$];
  logic [N_SRC-1:0] mon_vb[$];
  int n_done = 0, n_crc = 0, n_dst = 0, n_tmo = 0, n_multi = 0;

  always @(negedge clk) begin
    if (valid_bus != '0) begin
      mon_data.push_back(master_data);
      mon_vb.push_back(valid_bus);
      if (!$onehot(valid_bus)) n_multi++;
    end
    if (pkt_done)    n_done++;
    if (crc_err)     n_crc++;
    if (dst_err)     n_dst++;
    if (timeout_err) n_tmo++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_vb.delete();
    n_done = 0; n_crc = 0; n_dst = 0; n_tmo = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Back-to-back bytes; returns on the falling edge of the cycle after the
  // last byte was accepted.
  task automatic send_seq(input logic [7:0] s[$]);
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic check_delivery(input string tag, input logic [N_SRC-1:0] vb,
                                input logic [7:0] exp[$]);
    check_val({tag, "_nstrobe"}, mon_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < mon_data.size(); i++) begin
      check_val($sformatf("%s_data%0d", tag, i), mon_data[i], exp[i]);
      check_val($sformatf("%s_vb%0d", tag, i), mon_vb[i], vb);
    end
  endtask

  logic [7:0] seq[$];
  logic [7:0] exp[$];
  logic [7:0] good6[$];
  int         n;

  initial begin
    good6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    // ---------------- reset state ----------------
    idle(3);
    check_val("rst_outputs", {master_data, valid_bus, pkt_done, crc_err, dst_err,
                              timeout_err, overrun, busy}, 32'd0);
    check_val("rst_src_addr", src_addr, 8'h00);
    @(negedge clk);
    n_rst = 1'b1;
    idle(2);
    clear_mon();

    // ---------------- good packet ----------------
    seq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    send_seq(seq);
`ifdef PARSER_CRC_CHECK_EN
    idle(7);  // pkt_done at T+2+len
`endif
    check_val("good_done_timing", pkt_done, 1'b1);
    idle(12);
    check_delivery("good", 4'b0001, good6);
    check_val("good_ndone", n_done, 1);
    check_val("good_ncrc", n_crc, 0);
    check_val("good_src", src_addr, 8'h01);
    check_val("good_idle", busy, 1'b0);
    clear_mon();

    // ---------------- bad CRC ----------------
    seq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h16};
    send_seq(seq);
    idle(12);
`ifdef PARSER_CRC_CHECK_EN
    exp = {};
`else
    exp = good6;
`endif
    check_delivery("badcrc", 4'b0001, exp);
    check_val("badcrc_ncrc", n_crc, 1);
    check_val("badcrc_ndone", n_done, 0);
    clear_mon();

    // ---------------- bad destination, then good packet ----------------
    seq = '{8'hDD, 8'h01, 8'(N_SRC), 8'h01, 8'h01, 8'h01};
    send_seq(seq);
    idle(2);
    check_val("baddst_skip_done", busy, 1'b0);
    seq = '{8'hDD, 8'h03, 8'h02, 8'h02, 8'h10, 8'h20, 8'h30};
    send_seq(seq);
    idle(12);
    check_val("baddst_ndst", n_dst, 1);
    exp = '{8'h10, 8'h20};
    check_delivery("baddst_next", 4'b0100, exp);
    check_val("baddst_ndone", n_done, 1);
    check_val("baddst_src", src_addr, 8'h03);
    clear_mon();

    // ---------------- empty payload with leading garbage ----------------
    seq = '{8'h00, 8'h55, 8'hDD, 8'h01, 8'h00, 8'h00, 8'h00};
    send_seq(seq);
    idle(6);
    exp = {};
    check_delivery("empty", 4'b0001, exp);
    check_val("empty_ndone", n_done, 1);
    check_val("empty_ncrc", n_crc, 0);
    check_val("empty_ndst", n_dst, 0);
    clear_mon();

    // ---------------- timeout ----------------
    seq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01};
    send_seq(seq);
    n = 0;
    while (timeout_err !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check_val("tmo_latency", n, TMO);
    idle(3);
    check_val("tmo_ntmo", n_tmo, 1);
    check_val("tmo_idle", busy, 1'b0);
`ifdef PARSER_CRC_CHECK_EN
    exp = {};
`else
    exp = '{8'h01};
`endif
    check_delivery("tmo_partial", 4'b0001, exp);
    clear_mon();
    seq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    send_seq(seq);
    idle(12);
    check_delivery("tmo_next", 4'b0001, good6);
    check_val("tmo_next_ndone", n_done, 1);
    check_val("tmo_next_ntmo", n_tmo, 0);
    clear_mon();

    // ---------------- reset mid-packet ----------------
    seq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02};
    send_seq(seq);
    n_rst = 1'b0;
    idle(3);
    check_val("midrst_outputs", {master_data, valid_bus, pkt_done, crc_err, dst_err,
                                 timeout_err, overrun, busy}, 32'd0);
    check_val("midrst_src", src_addr, 8'h00);
    n_rst = 1'b1;
    idle(2);
    clear_mon();
    seq = '{8'hDD, 8'h05, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFF};
    send_seq(seq);
    idle(12);
    exp = '{8'hAA, 8'h55};
    check_delivery("midrst_next", 4'b0010, exp);
    check_val("midrst_ndone", n_done, 1);
    check_val("midrst_ncrc", n_crc, 0);
    check_val("midrst_src_new", src_addr, 8'h05);

    check_val("never_multihot", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
